// File: rtl/ovc_credit_tracker_pkg.sv
// Shared constants and types for the output-VC credit tracker.
// Credit width covers the deeper of the router and last-hop buffers.
package ovc_credit_tracker_pkg;

   localparam int B  = 4;
   localparam int LB = 4;

   function automatic int crdt_width(input int b, input int lb);
      int m;
      m = (b > lb) ? b : lb;
      return $clog2(m + 1);
   endfunction

   localparam int CRDTw = crdt_width(B, LB);

   typedef struct packed {
      logic [CRDTw-1:0] credit_init_val;
      logic             presence;
      logic             release_en;
   } ovc_credit_cfg_t;

endpackage

// File: rtl/ovc_credit_cell.sv
// One output VC: capacity, credit, deferred-release, allocation status and
// sticky error registers, plus the combinational flags derived from them.
module ovc_credit_cell
   import ovc_credit_tracker_pkg::*;
#(
   parameter int NF_TH          = 1,
   parameter int OVC_ALLOC_MODE = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             active,
   input  logic             present,
   input  ovc_credit_cfg_t  cfg,
   input  logic             inc,
   input  logic             dec,
   input  logic             alloc,
   input  logic             vc_release,
   output logic [CRDTw-1:0] credit,
   output logic             full,
   output logic             nearly_full,
   output logic             empty,
   output logic             status,
   output logic             avalable,
   output logic             err_overflow,
   output logic             err_underflow
);

   logic [CRDTw-1:0] cap;
   logic             pend;
   logic             rel_q;
   logic             rel_edge;

   assign rel_edge = ~rel_q & cfg.release_en & pend;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cap           <= cfg.presence ? cfg.credit_init_val : '0;
         credit        <= cfg.presence ? cfg.credit_init_val : '0;
         pend          <= 1'b0;
         status        <= 1'b0;
         err_overflow  <= 1'b0;
         err_underflow <= 1'b0;
         rel_q         <= 1'b0;
      end else begin
         rel_q <= cfg.release_en;
         if (present) begin
            // A deferred load replaces whatever credit traffic arrives alongside it.
            if (rel_edge) begin
               cap    <= cfg.credit_init_val;
               credit <= cfg.credit_init_val;
               pend   <= 1'b0;
            end else begin
               if (!active && (cap == '0))
                  pend <= 1'b1;
               if (inc && !dec) begin
                  if (credit == cap) err_overflow <= 1'b1;
                  else               credit <= credit + 1'b1;
               end else if (dec && !inc) begin
                  if (credit == '0) err_underflow <= 1'b1;
                  else              credit <= credit - 1'b1;
               end
            end
            // Alloc and release together is a single-flit packet: ends idle.
            if (alloc && !vc_release) status <= 1'b1;
            else if (vc_release)      status <= 1'b0;
         end
      end
   end

   assign full        = (credit == '0);
   assign nearly_full = (credit <= CRDTw'(NF_TH));
   assign empty       = (credit == cap);
   assign avalable    = active & present & ~pend & ~status &
                        ((OVC_ALLOC_MODE != 0) ? ~full : ~nearly_full);

endmodule

// File: rtl/ovc_credit_tracker.sv
// Per-output-port credit tracker for V output VCs; holds the port-wide
// active flag and presence mask and instantiates one cell per VC.
module ovc_credit_tracker
   import ovc_credit_tracker_pkg::*;
#(
   parameter int V              = 4,
   parameter int NF_TH          = 1,
   parameter int OVC_ALLOC_MODE = 1,
   parameter int HETERO_VC_EN   = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [V*CRDTw-1:0] credit_init_val,
   input  logic [V-1:0]       hetero_ovc_presence,
   input  logic [V-1:0]       credit_release_en,
   input  logic [V-1:0]       credit_in,
   input  logic               flit_wr,
   input  logic [V-1:0]       flit_vc,
   input  logic [V-1:0]       ovc_alloc,
   input  logic [V-1:0]       ovc_release,
   output logic [V*CRDTw-1:0] credit,
   output logic [V-1:0]       full,
   output logic [V-1:0]       nearly_full,
   output logic [V-1:0]       empty,
   output logic [V-1:0]       status,
   output logic [V-1:0]       avalable,
   output logic [V-1:0]       err_overflow,
   output logic [V-1:0]       err_underflow
);

   logic         active;
   logic [V-1:0] present;
   logic [V-1:0] pres_in;

   assign pres_in = (HETERO_VC_EN != 0) ? hetero_ovc_presence : '1;

   always_ff @(posedge clk) begin
      if (!reset) begin
         active  <= 1'b0;
         present <= pres_in;
      end else begin
         active  <= 1'b1;
      end
   end

   for (genvar v = 0; v < V; v++) begin : g_vc
      ovc_credit_cfg_t cfg;

      assign cfg.credit_init_val = credit_init_val[v*CRDTw +: CRDTw];
      assign cfg.presence        = pres_in[v];
      assign cfg.release_en      = credit_release_en[v];

      ovc_credit_cell #(
         .NF_TH          (NF_TH),
         .OVC_ALLOC_MODE (OVC_ALLOC_MODE)
      ) u_cell (
         .clk           (clk),
         .reset         (reset),
         .active        (active),
         .present       (present[v]),
         .cfg           (cfg),
         .inc           (credit_in[v]),
         .dec           (flit_wr & flit_vc[v]),
         .alloc         (ovc_alloc[v]),
         .vc_release    (ovc_release[v]),
         .credit        (credit[v*CRDTw +: CRDTw]),
         .full          (full[v]),
         .nearly_full   (nearly_full[v]),
         .empty         (empty[v]),
         .status        (status[v]),
         .avalable      (avalable[v]),
         .err_overflow  (err_overflow[v]),
         .err_underflow (err_underflow[v])
      );
   end

endmodule

// File: tb/tb_ovc_credit_tracker.sv
// Bench for ovc_credit_tracker: three configurations (default, hetero mask
// 4'b0011, nearly_full allocation mode) driven in parallel against a model.
module tb_ovc_credit_tracker;
   import ovc_credit_tracker_pkg::*;

   localparam int V  = 4;
   localparam int CW = CRDTw;
   localparam int NI = 3;

   logic               clk;
   logic               reset;
   logic [V*CW-1:0]    init_val;
   logic [V-1:0]       hop;
   logic [V-1:0]       rel_en;
   logic [V-1:0]       cin;
   logic               fwr;
   logic [V-1:0]       fvc;
   logic [V-1:0]       alloc;
   logic [V-1:0]       rls;

   logic [V*CW-1:0]    o_credit [NI];
   logic [V-1:0]       o_full [NI];
   logic [V-1:0]       o_nf [NI];
   logic [V-1:0]       o_empty [NI];
   logic [V-1:0]       o_status [NI];
   logic [V-1:0]       o_av [NI];
   logic [V-1:0]       o_of [NI];
   logic [V-1:0]       o_uf [NI];

   int n_cmp;
   int n_fail;

   // model state, indexed [instance][vc]
   int hetero_c [NI] = '{0, 1, 0};
   int mode_c   [NI] = '{1, 1, 0};
   int m_cap  [NI][V];
   int m_cred [NI][V];
   bit m_pend [NI][V];
   bit m_stat [NI][V];
   bit m_of   [NI][V];
   bit m_uf   [NI][V];
   bit m_relq [NI][V];
   bit m_pres [NI][V];
   bit m_active [NI];

   string flag_name [7] = '{"full", "nearly_full", "empty", "status", "avalable", "err_overflow", "err_underflow"};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   ovc_credit_tracker #(.HETERO_VC_EN(0), .OVC_ALLOC_MODE(1)) dut0 (
      .clk(clk), .reset(reset), .credit_init_val(init_val), .hetero_ovc_presence(hop),
      .credit_release_en(rel_en), .credit_in(cin), .flit_wr(fwr), .flit_vc(fvc),
      .ovc_alloc(alloc), .ovc_release(rls), .credit(o_credit[0]), .full(o_full[0]),
      .nearly_full(o_nf[0]), .empty(o_empty[0]), .status(o_status[0]), .avalable(o_av[0]),
      .err_overflow(o_of[0]), .err_underflow(o_uf[0]));

   ovc_credit_tracker #(.HETERO_VC_EN(1), .OVC_ALLOC_MODE(1)) dut1 (
      .clk(clk), .reset(reset), .credit_init_val(init_val), .hetero_ovc_presence(hop),
      .credit_release_en(rel_en), .credit_in(cin), .flit_wr(fwr), .flit_vc(fvc),
      .ovc_alloc(alloc), .ovc_release(rls), .credit(o_credit[1]), .full(o_full[1]),
      .nearly_full(o_nf[1]), .empty(o_empty[1]), .status(o_status[1]), .avalable(o_av[1]),
      .err_overflow(o_of[1]), .err_underflow(o_uf[1]));

   ovc_credit_tracker #(.HETERO_VC_EN(0), .OVC_ALLOC_MODE(0)) dut2 (
      .clk(clk), .reset(reset), .credit_init_val(init_val), .hetero_ovc_presence(hop),
      .credit_release_en(rel_en), .credit_in(cin), .flit_wr(fwr), .flit_vc(fvc),
      .ovc_alloc(alloc), .ovc_release(rls), .credit(o_credit[2]), .full(o_full[2]),
      .nearly_full(o_nf[2]), .empty(o_empty[2]), .status(o_status[2]), .avalable(o_av[2]),
      .err_overflow(o_of[2]), .err_underflow(o_uf[2]));

   function automatic int init_of(int v);
      logic [V*CW-1:0] t;
      t = init_val;
      return int'(t[v*CW +: CW]);
   endfunction

   // Reference behaviour applied at every rising edge from the sampled inputs.
   function automatic void model_step();
      for (int c = 0; c < NI; c++) begin
         if (!reset) begin
            for (int v = 0; v < V; v++) begin
               m_pres[c][v] = (hetero_c[c] != 0) ? hop[v] : 1'b1;
               m_cap[c][v]  = m_pres[c][v] ? init_of(v) : 0;
               m_cred[c][v] = m_cap[c][v];
               m_pend[c][v] = 0; m_stat[c][v] = 0; m_of[c][v] = 0;
               m_uf[c][v]   = 0; m_relq[c][v] = 0;
            end
            m_active[c] = 0;
         end else begin
            for (int v = 0; v < V; v++) begin
               bit inc;
               bit dec;
               inc = cin[v];
               dec = fwr && fvc[v];
               if (m_pres[c][v]) begin
                  if (!m_relq[c][v] && rel_en[v] && m_pend[c][v]) begin
                     m_cap[c][v]  = init_of(v);
                     m_cred[c][v] = init_of(v);
                     m_pend[c][v] = 0;
                  end else begin
                     if (!m_active[c] && m_cap[c][v] == 0) m_pend[c][v] = 1;
                     if (inc && !dec) begin
                        if (m_cred[c][v] == m_cap[c][v]) m_of[c][v] = 1;
                        else m_cred[c][v] = m_cred[c][v] + 1;
                     end else if (dec && !inc) begin
                        if (m_cred[c][v] == 0) m_uf[c][v] = 1;
                        else m_cred[c][v] = m_cred[c][v] - 1;
                     end
                  end
                  if (alloc[v] && !rls[v]) m_stat[c][v] = 1;
                  else if (rls[v])         m_stat[c][v] = 0;
               end
               m_relq[c][v] = rel_en[v];
            end
            m_active[c] = 1;
         end
      end
   endfunction

   function automatic logic [V*CW-1:0] exp_credit(int c);
      logic [V*CW-1:0] r;
      r = '0;
      for (int v = 0; v < V; v++) r[v*CW +: CW] = CW'(m_cred[c][v]);
      return r;
   endfunction

   function automatic logic [V-1:0] exp_flag(int c, int k);
      logic [V-1:0] r;
      bit f;
      bit nf;
      r = '0;
      for (int v = 0; v < V; v++) begin
         f  = (m_cred[c][v] == 0);
         nf = (m_cred[c][v] <= 1);
         case (k)
            0: r[v] = f;
            1: r[v] = nf;
            2: r[v] = (m_cred[c][v] == m_cap[c][v]);
            3: r[v] = m_stat[c][v];
            4: r[v] = m_active[c] && m_pres[c][v] && !m_pend[c][v] && !m_stat[c][v] &&
                      ((mode_c[c] != 0) ? !f : !nf);
            5: r[v] = m_of[c][v];
            default: r[v] = m_uf[c][v];
         endcase
      end
      return r;
   endfunction

   function automatic logic [V-1:0] get_flag(int c, int k);
      case (k)
         0: return o_full[c];
         1: return o_nf[c];
         2: return o_empty[c];
         3: return o_status[c];
         4: return o_av[c];
         5: return o_of[c];
         default: return o_uf[c];
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_init(input int a, input int b, input int c, input int d);
      init_val = {CW'(d), CW'(c), CW'(b), CW'(a)};
   endtask

   task automatic idle();
      cin = '0; fwr = 1'b0; fvc = '0; alloc = '0; rls = '0;
   endtask

   task automatic test_reset();
      set_init(4, 4, 4, 4);
      rel_en = '0; idle(); reset = 1'b0;
      tick(); tick();
      n_cmp++; if (o_credit[0] !== {4{3'd4}}) begin n_fail++; $display("FAIL reset_credit got %h want %h", o_credit[0], {4{3'd4}}); end
      n_cmp++; if (o_av[0] !== 4'h0) begin n_fail++; $display("FAIL reset_avalable got %b want 0000", o_av[0]); end
      n_cmp++; if (o_empty[0] !== 4'hF) begin n_fail++; $display("FAIL reset_empty got %b want 1111", o_empty[0]); end
      n_cmp++; if (o_credit[1] !== {3'd0, 3'd0, 3'd4, 3'd4}) begin n_fail++; $display("FAIL reset_hetero_credit got %h want %h", o_credit[1], {3'd0, 3'd0, 3'd4, 3'd4}); end
      n_cmp++; if (o_full[1] !== 4'b1100) begin n_fail++; $display("FAIL reset_hetero_full got %b want 1100", o_full[1]); end
      reset = 1'b1;
      tick();
      n_cmp++; if (o_av[0] !== 4'hF) begin n_fail++; $display("FAIL active_avalable got %b want 1111", o_av[0]); end
      n_cmp++; if (o_av[1] !== 4'b0011) begin n_fail++; $display("FAIL active_hetero_avalable got %b want 0011", o_av[1]); end
   endtask

   task automatic test_count_down();
      for (int i = 0; i < 4; i++) begin
         fwr = 1'b1; fvc = 4'b0001;
         tick();
         n_cmp++; if (o_credit[0][2:0] !== 3'(3 - i)) begin n_fail++; $display("FAIL count_down credit0 got %0d want %0d", o_credit[0][2:0], 3 - i); end
      end
      idle();
      n_cmp++; if (o_full[0][0] !== 1'b1) begin n_fail++; $display("FAIL count_down full0 got %b want 1", o_full[0][0]); end
      n_cmp++; if (o_av[0][0] !== 1'b0) begin n_fail++; $display("FAIL count_down avalable0 got %b want 0", o_av[0][0]); end
      cin = 4'b0001;
      tick();
      idle();
      n_cmp++; if (o_credit[0][2:0] !== 3'd1) begin n_fail++; $display("FAIL credit_return credit0 got %0d want 1", o_credit[0][2:0]); end
      n_cmp++; if (o_av[0][0] !== 1'b1) begin n_fail++; $display("FAIL credit_return avalable0 got %b want 1", o_av[0][0]); end
      n_cmp++; if (o_av[2][0] !== 1'b0) begin n_fail++; $display("FAIL nf_mode avalable0 got %b want 0", o_av[2][0]); end
   endtask

   task automatic test_inc_dec();
      fwr = 1'b1; fvc = 4'b0010;
      tick(); tick();
      cin = 4'b0010;
      tick();
      idle();
      n_cmp++; if (o_credit[0][5:3] !== 3'd2) begin n_fail++; $display("FAIL inc_dec credit1 got %0d want 2", o_credit[0][5:3]); end
      n_cmp++; if ((o_of[0] | o_uf[0]) !== 4'h0) begin n_fail++; $display("FAIL inc_dec errors got %b want 0000", o_of[0] | o_uf[0]); end
   endtask

   task automatic test_errors();
      cin = 4'b0100;
      tick();
      idle();
      n_cmp++; if (o_of[0][2] !== 1'b1) begin n_fail++; $display("FAIL overflow flag got %b want 1", o_of[0][2]); end
      n_cmp++; if (o_credit[0][8:6] !== 3'd4) begin n_fail++; $display("FAIL overflow credit2 got %0d want 4", o_credit[0][8:6]); end
      n_cmp++; if (o_of[1][2] !== 1'b0) begin n_fail++; $display("FAIL overflow_absent got %b want 0", o_of[1][2]); end
      tick(); tick();
      n_cmp++; if (o_of[0][2] !== 1'b1) begin n_fail++; $display("FAIL overflow_sticky got %b want 1", o_of[0][2]); end
      fwr = 1'b1; fvc = 4'b0001;
      tick(); tick();
      idle();
      n_cmp++; if (o_uf[0][0] !== 1'b1) begin n_fail++; $display("FAIL underflow flag got %b want 1", o_uf[0][0]); end
      n_cmp++; if (o_credit[0][2:0] !== 3'd0) begin n_fail++; $display("FAIL underflow credit0 got %0d want 0", o_credit[0][2:0]); end
   endtask

   task automatic test_status();
      alloc = 4'b1000; rls = 4'b1000;
      tick();
      n_cmp++; if (o_status[0][3] !== 1'b0) begin n_fail++; $display("FAIL single_flit status3 got %b want 0", o_status[0][3]); end
      rls = 4'b0000;
      tick();
      idle();
      n_cmp++; if (o_status[0][3] !== 1'b1) begin n_fail++; $display("FAIL alloc status3 got %b want 1", o_status[0][3]); end
      n_cmp++; if (o_av[0][3] !== 1'b0) begin n_fail++; $display("FAIL alloc avalable3 got %b want 0", o_av[0][3]); end
      n_cmp++; if (o_status[1][3] !== 1'b0) begin n_fail++; $display("FAIL alloc_absent status3 got %b want 0", o_status[1][3]); end
      rls = 4'b1000;
      tick();
      idle();
      n_cmp++; if (o_av[0][3] !== 1'b1) begin n_fail++; $display("FAIL release avalable3 got %b want 1", o_av[0][3]); end
   endtask

   task automatic test_deferred();
      set_init(4, 4, 0, 4);
      rel_en = 4'b0100; idle(); reset = 1'b0;
      tick(); tick();
      reset = 1'b1;
      tick(); tick(); tick();
      n_cmp++; if (o_credit[0][8:6] !== 3'd0) begin n_fail++; $display("FAIL deferred_hold credit2 got %0d want 0", o_credit[0][8:6]); end
      n_cmp++; if (o_av[0][2] !== 1'b0) begin n_fail++; $display("FAIL deferred_hold avalable2 got %b want 0", o_av[0][2]); end
      set_init(4, 4, 4, 4);
      rel_en = 4'b0000;
      tick();
      rel_en = 4'b0100;
      tick();
      n_cmp++; if (o_credit[0][8:6] !== 3'd4) begin n_fail++; $display("FAIL deferred_load credit2 got %0d want 4", o_credit[0][8:6]); end
      n_cmp++; if (o_empty[0][2] !== 1'b1) begin n_fail++; $display("FAIL deferred_load empty2 got %b want 1", o_empty[0][2]); end
      n_cmp++; if (o_av[0][2] !== 1'b1) begin n_fail++; $display("FAIL deferred_load avalable2 got %b want 1", o_av[0][2]); end
      fwr = 1'b1; fvc = 4'b0100; rel_en = 4'b0000;
      tick();
      idle(); rel_en = 4'b0100;
      tick();
      n_cmp++; if (o_credit[0][8:6] !== 3'd3) begin n_fail++; $display("FAIL deferred_reedge credit2 got %0d want 3", o_credit[0][8:6]); end
      rel_en = 4'b0000;
   endtask

   task automatic test_hetero();
      cin = 4'b1000; fwr = 1'b1; fvc = 4'b1000;
      tick();
      n_cmp++; if (o_credit[0][11:9] !== 3'd4) begin n_fail++; $display("FAIL hetero_present credit3 got %0d want 4", o_credit[0][11:9]); end
      fwr = 1'b0;
      tick();
      cin = 4'b0000; fwr = 1'b1;
      tick();
      idle();
      n_cmp++; if (o_credit[1][11:9] !== 3'd0) begin n_fail++; $display("FAIL hetero_absent credit3 got %0d want 0", o_credit[1][11:9]); end
      n_cmp++; if (o_av[1][3] !== 1'b0) begin n_fail++; $display("FAIL hetero_absent avalable3 got %b want 0", o_av[1][3]); end
      n_cmp++; if ({o_of[1][3], o_uf[1][3]} !== 2'b00) begin n_fail++; $display("FAIL hetero_absent errors3 got %b want 00", {o_of[1][3], o_uf[1][3]}); end
      n_cmp++; if ({o_full[1][3], o_nf[1][3], o_empty[1][3]} !== 3'b111) begin n_fail++; $display("FAIL hetero_absent flags3 got %b want 111", {o_full[1][3], o_nf[1][3], o_empty[1][3]}); end
   endtask

   task automatic test_mid_reset();
      set_init(1, 2, 3, 4);
      reset = 1'b0; cin = 4'b1111; fwr = 1'b1; fvc = 4'b0001; alloc = 4'b1111;
      tick();
      idle();
      n_cmp++; if (o_credit[0] !== {3'd4, 3'd3, 3'd2, 3'd1}) begin n_fail++; $display("FAIL mid_reset credit got %h want %h", o_credit[0], {3'd4, 3'd3, 3'd2, 3'd1}); end
      n_cmp++; if ((o_status[0] | o_of[0] | o_uf[0] | o_av[0]) !== 4'h0) begin n_fail++; $display("FAIL mid_reset state got %b want 0000", o_status[0] | o_of[0] | o_uf[0] | o_av[0]); end
      reset = 1'b1;
      tick();
   endtask

   task automatic test_random();
      for (int v = 0; v < V; v++) init_val[v*CW +: CW] = CW'($urandom_range(0, 4));
      reset = 1'b0; idle(); rel_en = '0;
      tick();
      for (int cyc = 0; cyc < 600; cyc++) begin
         reset = ($urandom_range(0, 59) != 0);
         if ($urandom_range(0, 9) == 0)
            for (int v = 0; v < V; v++) init_val[v*CW +: CW] = CW'($urandom_range(0, 4));
         for (int v = 0; v < V; v++)
            if ($urandom_range(0, 7) == 0) rel_en[v] = ~rel_en[v];
         cin   = V'($urandom_range(0, 15)) & V'($urandom_range(0, 15));
         fwr   = ($urandom_range(0, 2) != 0);
         fvc   = V'(1) << $urandom_range(0, V - 1);
         alloc = V'($urandom_range(0, 15)) & V'($urandom_range(0, 15));
         rls   = V'($urandom_range(0, 15)) & V'($urandom_range(0, 15));
         tick();
         for (int c = 0; c < NI; c++) begin
            n_cmp++;
            if (o_credit[c] !== exp_credit(c)) begin
               n_fail++;
               $display("FAIL rand_credit inst%0d cyc%0d got %h want %h", c, cyc, o_credit[c], exp_credit(c));
            end
            for (int k = 0; k < 7; k++) begin
               n_cmp++;
               if (get_flag(c, k) !== exp_flag(c, k)) begin
                  n_fail++;
                  $display("FAIL rand_%s inst%0d cyc%0d got %b want %b", flag_name[k], c, cyc, get_flag(c, k), exp_flag(c, k));
               end
            end
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      reset = 1'b0; hop = 4'b0011; rel_en = '0; init_val = '0;
      idle();
      test_reset();
      test_count_down();
      test_inc_dec();
      test_errors();
      test_status();
      test_deferred();
      test_hetero();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ovc_credit_tracker.md
Name: ovc_credit_tracker

Overview:
- Per-output-port tracker for V output VCs in a router or endpoint NI.
- Tracks per-VC credit count, allocation status and full/nearly_full/empty flags, and computes per-VC availability for the VC allocator.
- Generalises the plain credit counter: per-VC initial credit captured during reset, deferred credit release for VCs initialised at zero, heterogeneous VC presence masking, selectable allocation mode, and sticky overflow/underflow error flags.
- Sits between the switch-allocator/crossbar write path and the VSA/SSA/SMART allocators.

Parameters:
- V, 4, number of VCs per port.
- B, 4, router buffer depth (flits per VC).
- LB, 4, last-hop (endpoint-facing) buffer depth.
- CRDTw, derived, log2(max(B,LB)+1): credit counter width.
- NF_TH, 1, nearly_full asserted when credit <= NF_TH.
- OVC_ALLOC_MODE, 1:
  - 1: VC is available when not full.
  - 0: VC is available when not nearly_full.
- HETERO_VC_EN, 0: 1 honours hetero_ovc_presence; 0 treats all VCs as present.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- credit_init_val  in  V*CRDTw  per-VC initial credit, sampled every cycle while reset is asserted.
- hetero_ovc_presence  in  V  per-VC presence mask, sampled while reset is asserted.
- credit_release_en  in  V  a rising edge loads the deferred credit for a VC whose captured init value was 0.
- credit_in  in  V  credit return from downstream; any combination of bits may be set in one cycle.
- flit_wr  in  1  a flit is sent this cycle.
- flit_vc  in  V  one-hot VC of the sent flit; qualified by flit_wr.
- ovc_alloc  in  V  VC allocated to a packet this cycle.
- ovc_release  in  V  VC released (tail flit sent) this cycle.
- credit  out  V*CRDTw  current per-VC credit.
- full  out  V  credit == 0.
- nearly_full  out  V  credit <= NF_TH.
- empty  out  V  credit == captured capacity.
- status  out  V  1 = VC allocated.
- avalable  out  V  VC can be granted to a new packet.
- err_overflow  out  V  sticky; credit returned while credit was at capacity.
- err_underflow  out  V  sticky; flit sent while credit was 0.

Behaviour:
- Reset (reset==0, synchronous):
  - cap[v] <= credit_init_val[v] & present[v]; credit[v] <= the same value.
  - present <= HETERO_VC_EN ? hetero_ovc_presence : all ones.
  - status, both error flags, pend and the release-edge register all clear to 0.
  - active <= 0. While active==0, avalable is forced to 0.
- Cycle after reset deasserts: active <= 1.
- pend[v] is set on the first active cycle if cap[v]==0 and present[v]==1.
- Deferred release: on rel_q[v]==0 && credit_release_en[v]==1 && pend[v]:
  - cap[v] <= credit_init_val[v]; credit[v] <= credit_init_val[v]; pend[v] <= 0.
  - Edges on a VC with pend[v]==0 are ignored.
- Credit update per present VC, one-cycle latency. Let dec = flit_wr & flit_vc[v] and inc = credit_in[v]:
  - inc & dec: credit unchanged.
  - inc only: if credit==cap, hold the value and set err_overflow[v]; otherwise +1.
  - dec only: if credit==0, hold 0 and set err_underflow[v]; otherwise -1.
- Status per present VC:
  - alloc only: set.
  - release only: clear.
  - alloc and release in the same cycle (single-flit packet): status stays 0.
- Flags are combinational from registered credit and cap: full, nearly_full, empty.
- avalable[v] = active & present[v] & ~pend[v] & ~status[v] & (OVC_ALLOC_MODE ? ~full[v] : ~nearly_full[v]).
- Non-present VCs:
  - credit 0, full=1, nearly_full=1, empty=1, status 0, avalable 0.
  - All inputs ignored; no error flags set.
- flit_vc that is not one-hot while flit_wr==1: the bench treats this as a protocol violation; the behaviour is undefined.
- Reset asserted mid-operation: all state reloads as described above within one cycle, regardless of in-flight inputs.

Decomposition:
- Shared package gains:
  - the ovc_credit_cfg_t typedef (credit_init_val, presence, release_en), a subset of ctrl_chanel_t;
  - CRDTw, already defined as a package constant.
- One sub-module, ovc_credit_cell: one VC's cap/credit/pend/status/error registers plus its flags.
  - The top level instantiates V cells in a generate loop, and holds the active register and the presence mask.

Test Plan:
- Reset with init {4,4,4,4}, then 4 flit_wr on VC0 → credit0 counts 3,2,1,0; full0=1 and avalable0=0 after the 4th; one credit_in → credit0=1, avalable0=1.
- credit_in and flit_wr on VC1 in the same cycle with credit1=2 → credit1 stays 2, no error flags.
- Reset with VC2 init 0; credit_release_en2 held high during and after reset → no load. Drive init 4, then 0→1 edge → credit2=4, empty2=1, avalable2=1 one cycle later.
- HETERO_VC_EN=1, presence 4'b0011, credit_in and flit_wr on VC3 → credit3=0, avalable3=0, err flags for VC3 stay 0.
- credit_in on a VC at cap=4 → err_overflow=1 (sticky), credit stays 4; flit_wr at credit 0 → err_underflow=1, credit stays 0.
- ovc_alloc and ovc_release on VC0 in the same cycle → status0=0; ovc_alloc alone → status0=1, avalable0=0. With OVC_ALLOC_MODE=0, NF_TH=1, credit=1 → avalable=0.
